// File: rtl/proc_pkg.sv
// Shared processor constants: instruction/next-PC widths and the NOP encoding
// that the prefetch buffer presents when it has nothing to issue.
package proc_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/instr_prefetch_buf_ptr_wrap.sv
// Modulo-DEPTH pointer used for the head and tail of the prefetch buffer.
module ptr_wrap #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] ptr_d;
    logic [AW-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (en) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch FIFO between fetch and IF/ID.
// Optional zero-latency empty-buffer bypass: define PREFETCH_BYPASS_EN.
module instr_prefetch_buf
    import proc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = proc_pkg::INSTR_W,
    parameter int PC_W    = proc_pkg::PC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic [PC_W-1:0]          push_pc,
    output logic                     push_ready,
    input  logic                     flush,
    input  logic                     stall,
    output logic                     pop_valid,
    output logic [INSTR_W-1:0]       pop_instr,
    output logic [PC_W-1:0]          pop_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [CW-1:0]      count_d;
    logic [CW-1:0]      count_q;
    logic               err_d;
    logic               err_q;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];

    logic empty;
    logic full;
    logic push_fire;
    logic pop_fire;
    logic wr_en;
    logic rd_en;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        push_ready = !full;
        push_fire  = push_valid && !full && !flush;

`ifdef PREFETCH_BYPASS_EN
        pop_valid = empty ? (push_valid && !flush) : !flush;
`else
        pop_valid = !empty && !flush;
`endif
        pop_fire = pop_valid && !stall;
        rd_en    = pop_fire && !empty;
        // An entry consumed straight off the push port is never stored.
        wr_en    = push_fire && !(pop_fire && empty);

        pop_instr = INSTR_W'(NOP_INSTR);
        pop_pc    = '0;
        if (pop_valid) begin
`ifdef PREFETCH_BYPASS_EN
            if (empty) begin
                pop_instr = push_instr;
                pop_pc    = push_pc;
            end else begin
                pop_instr = instr_mem_q[head];
                pop_pc    = pc_mem_q[head];
            end
`else
            pop_instr = instr_mem_q[head];
            pop_pc    = pc_mem_q[head];
`endif
        end

        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Overflow is sticky; only reset clears it.
        err_d = err_q || (push_valid && full && !flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem_q[tail] <= push_instr;
            pc_mem_q[tail]    <= push_pc;
        end
    end

    ptr_wrap #(.DEPTH(DEPTH)) u_head (
        .clk (clk),
        .rst (rst),
        .en  (rd_en),
        .clr (flush),
        .ptr (head)
    );

    ptr_wrap #(.DEPTH(DEPTH)) u_tail (
        .clk (clk),
        .rst (rst),
        .en  (wr_en),
        .clr (flush),
        .ptr (tail)
    );

    assign count = count_q;
    assign err   = err_q;

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Directed bench for instr_prefetch_buf with a queue-based reference model.
module tb_instr_prefetch_buf;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic [15:0]   push_instr = '0;
    logic [15:0]   push_pc = '0;
    logic          push_ready;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic          pop_valid;
    logic [15:0]   pop_instr;
    logic [15:0]   pop_pc;
    logic [CW-1:0] count;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mq_i[$];
    logic [15:0] mq_p[$];
    bit          m_err = 1'b0;

    instr_prefetch_buf #(.DEPTH(DEPTH), .INSTR_W(16), .PC_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_instr (push_instr),
        .push_pc    (push_pc),
        .push_ready (push_ready),
        .flush      (flush),
        .stall      (stall),
        .pop_valid  (pop_valid),
        .pop_instr  (pop_instr),
        .pop_pc     (pop_pc),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: FIFO as a queue; outputs derived from its size and the live inputs.
    always @(posedge clk or posedge rst) begin : model
        int sz;
        bit pv;
        bit pf;
        if (rst) begin
            mq_i.delete();
            mq_p.delete();
            m_err = 1'b0;
        end else if (flush) begin
            mq_i.delete();
            mq_p.delete();
        end else begin
            sz = mq_i.size();
            pv = (sz != 0) || (BYP && push_valid);
            pf = pv && !stall;
            if (push_valid && sz == DEPTH) m_err = 1'b1;
            if (pf && sz != 0) begin
                void'(mq_i.pop_front());
                void'(mq_p.pop_front());
            end
            if (push_valid && sz != DEPTH && !(pf && sz == 0)) begin
                mq_i.push_back(push_instr);
                mq_p.push_back(push_pc);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        epv;
        logic [15:0] epi;
        logic [15:0] epp;
        epi = 16'h0800;
        epp = 16'h0000;
        if (mq_i.size() != 0) epv = !flush;
        else                  epv = BYP && push_valid && !flush;
        if (epv) begin
            if (mq_i.size() != 0) begin
                epi = mq_i[0];
                epp = mq_p[0];
            end else begin
                epi = push_instr;
                epp = push_pc;
            end
        end
        chk("m_pop_valid", 32'(pop_valid), 32'(epv));
        chk("m_pop_instr", 32'(pop_instr), 32'(epi));
        chk("m_pop_pc", 32'(pop_pc), 32'(epp));
        chk("m_count", 32'(count), 32'(mq_i.size()));
        chk("m_push_ready", 32'(push_ready), 32'(mq_i.size() != DEPTH));
        chk("m_err", 32'(err), 32'(m_err));
    end

    task automatic cyc(input logic pv, input logic [15:0] i, input logic [15:0] p,
                       input logic fl, input logic st);
        @(posedge clk);
        #1;
        push_valid = pv;
        push_instr = i;
        push_pc    = p;
        flush      = fl;
        stall      = st;
        #2;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        @(posedge clk);
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pop_instr", 32'(pop_instr), 32'h0800);
        chk("rst_pop_pc", 32'(pop_pc), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back pushes with no stall.
        cyc(1'b1, 16'h1111, 16'h0002, 1'b0, 1'b0);
`ifndef PREFETCH_BYPASS_EN
        chk("b2b_c0_count", 32'(count), 32'd0);
        chk("b2b_c0_valid", 32'(pop_valid), 32'd0);
`endif
        cyc(1'b1, 16'h2222, 16'h0004, 1'b0, 1'b0);
`ifndef PREFETCH_BYPASS_EN
        chk("b2b_c1_instr", 32'(pop_instr), 32'h1111);
        chk("b2b_c1_pc", 32'(pop_pc), 32'h0002);
        chk("b2b_c1_count", 32'(count), 32'd1);
`endif
        cyc(1'b1, 16'h3333, 16'h0006, 1'b0, 1'b0);
`ifndef PREFETCH_BYPASS_EN
        chk("b2b_c2_instr", 32'(pop_instr), 32'h2222);
        chk("b2b_c2_count", 32'(count), 32'd1);
`endif
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifndef PREFETCH_BYPASS_EN
        chk("b2b_c3_instr", 32'(pop_instr), 32'h3333);
        chk("b2b_c3_pc", 32'(pop_pc), 32'h0006);
`endif
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("b2b_end_count", 32'(count), 32'd0);
        chk("b2b_end_instr", 32'(pop_instr), 32'h0800);

        // Asynchronous reset between edges with two entries held.
        cyc(1'b1, 16'hD001, 16'h0010, 1'b0, 1'b1);
        cyc(1'b1, 16'hD002, 16'h0012, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        chk("arst_pre_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(pop_valid), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_ready", 32'(push_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill while stalled, overflow, then drain in order.
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 16'hA001 + 16'(k), 16'h0020 + 16'(2 * k), 1'b0, 1'b1);
        cyc(1'b1, 16'hA005, 16'h0028, 1'b0, 1'b1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(push_ready), 32'd0);
        chk("full_head", 32'(pop_instr), 32'hA001);
        chk("full_err_pre", 32'(err), 32'd0);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", 32'(pop_instr), 32'hA001);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            chk("drain_instr", 32'(pop_instr), 32'hA001 + 32'(k));
            chk("drain_pc", 32'(pop_pc), 32'h0020 + 32'(2 * k));
        end
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("drain_count", 32'(count), 32'd0);

        // Push and flush together with three entries buffered.
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 16'hB001 + 16'(k), 16'h0030 + 16'(2 * k), 1'b0, 1'b1);
        cyc(1'b1, 16'hB004, 16'h0036, 1'b1, 1'b1);
        chk("flush_cur_count", 32'(count), 32'd3);
        chk("flush_cur_valid", 32'(pop_valid), 32'd0);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(pop_valid), 32'd0);
        chk("flush_instr", 32'(pop_instr), 32'h0800);

        // Continuous streaming of ten entries; pointers wrap twice.
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 16'hC000 + 16'(k), 16'h0040 + 16'(2 * k), 1'b0, 1'b0);
`ifndef PREFETCH_BYPASS_EN
            if (k > 0) begin
                chk("wrap_instr", 32'(pop_instr), 32'hC000 + 32'(k - 1));
                chk("wrap_count", 32'(count), 32'd1);
            end
`endif
        end
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifndef PREFETCH_BYPASS_EN
        chk("wrap_last", 32'(pop_instr), 32'hC009);
`endif
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("wrap_end_count", 32'(count), 32'd0);

`ifdef PREFETCH_BYPASS_EN
        // Zero-latency bypass on an empty buffer.
        cyc(1'b1, 16'hABCD, 16'h0050, 1'b0, 1'b0);
        chk("byp_valid", 32'(pop_valid), 32'd1);
        chk("byp_instr", 32'(pop_instr), 32'hABCD);
        chk("byp_pc", 32'(pop_pc), 32'h0050);
        chk("byp_count", 32'(count), 32'd0);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("byp_after_count", 32'(count), 32'd0);
        chk("byp_after_valid", 32'(pop_valid), 32'd0);
`endif

        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buf.md
INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered instructions; power of two, 2..16.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-003 SHALL have parameter PC_W, default 16, next-PC width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port push_valid, input, 1, fetch stage presents an instruction.
REQ-008 SHALL have port push_instr, input, INSTR_W, fetched instruction word.
REQ-009 SHALL have port push_pc, input, PC_W, PC+2 of the fetched instruction.
REQ-010 SHALL have port push_ready, output, 1, buffer can accept an entry this cycle.
REQ-011 SHALL have port flush, input, 1, taken branch/jump resolved in MEM; discard contents.
REQ-012 SHALL have port stall, input, 1, IF/ID register holds; no pop this cycle.
REQ-013 SHALL have port pop_valid, output, 1, head entry is valid for IF/ID.
REQ-014 SHALL have port pop_instr, output, INSTR_W, head instruction.
REQ-015 SHALL have port pop_pc, output, PC_W, head next-PC.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1, number of occupied entries.
REQ-017 SHALL have port err, output, 1, sticky overflow flag.

Function
REQ-018 Push fires on push_valid && push_ready && !flush; entry written at tail, tail advances.
REQ-019 push_ready SHALL equal (count != DEPTH), combinational, independent of pop.
REQ-020 pop_valid SHALL equal (count != 0) && !flush; pop_instr/pop_pc SHALL show the head entry combinationally.
REQ-021 Pop fires on pop_valid && !stall; head advances on the next edge.
REQ-022 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
REQ-023 Head and tail SHALL wrap modulo DEPTH; order is strictly FIFO.
REQ-024 Without bypass, an entry pushed at edge N is first visible on pop at cycle N+1 (one-cycle latency).
REQ-025 flush SHALL zero count, head and tail at the next edge; it dominates push and pop in the same cycle.
REQ-026 When full, pop_instr/pop_pc and storage SHALL be unaffected by push_valid.
REQ-027 push_valid && !push_ready && !flush SHALL set err at the next edge; the instruction is dropped; err holds until rst.
REQ-028 When pop_valid is 0, pop_instr SHALL read 16'h0800 (NOP) and pop_pc SHALL read 0.

Reset
REQ-029 On rst: count=0, head=tail=0, err=0, pop_valid=0, push_ready=1; storage contents need not be cleared.
REQ-030 rst asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro PREFETCH_BYPASS_EN: when defined and count==0, pop_valid=push_valid&&!flush and pop_instr/pop_pc=push inputs (zero latency); if the pop fires, the entry is not stored.
REQ-032 Without PREFETCH_BYPASS_EN: no combinational path from push_* to pop_*; REQ-024 latency applies.

Structure
REQ-033 INSTR_W, PC_W and the NOP encoding constant SHALL live in shared package proc_pkg.
REQ-034 One sub-module SHALL exist, ptr_wrap (modulo-DEPTH pointer with enable and sync clear); head and tail each instantiate it.
REQ-035 Storage SHALL be an inline register array; no SRAM macro.

Verification
REQ-036 Push 0x1111,0x2222,0x3333 back-to-back, stall=0 -> pops in order, each one cycle after its push; count peaks at 1.
REQ-037 stall=1, push 4 entries -> count=4, push_ready=0; 5th push -> err=1, entry dropped; release stall -> 4 original entries out in order.
REQ-038 count=3, push and flush in the same cycle -> next cycle count=0, pop_valid=0, pop_instr=0x0800.
REQ-039 Push/pop 10 entries continuously with DEPTH=4 -> pointers wrap twice, no loss or reordering.
REQ-040 Assert rst between edges with count=2 -> count=0 and pop_valid=0 immediately; err remains 0.
REQ-041 With PREFETCH_BYPASS_EN, empty buffer, push 0xABCD, stall=0 -> pop_instr=0xABCD in the same cycle; count stays 0.
